// File: rtl/jtag_scan_master.sv
// JTAG scan sequencer: TAP reset, DR/IR scan and idle-run driven from a start/busy/done handshake.
// Define JTAG_SCAN_IDLE_EN to append IDLE_TCKS Run-Test/Idle clocks after every DR/IR scan.
//
// state  | meaning
// IDLE   | waiting for start, TAP parked (TMS held)
// RUN    | clocking the per-command TMS/TDI schedule
// FINISH | done pulse, busy cleared; a new start is accepted here too
module jtag_scan_master #(
  parameter int MAX_LEN   = 64,
  parameter int LEN_W     = 7,
  parameter int CLK_DIV   = 2,
  parameter int IDLE_TCKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         cmd,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] tdi_data,
  output logic [MAX_LEN-1:0] tdo_data,
  output logic               busy,
  output logic               done,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  localparam logic [1:0] CMD_DR   = 2'b00;
  localparam logic [1:0] CMD_IR   = 2'b01;
  localparam logic [1:0] CMD_RST  = 2'b10;
  localparam logic [1:0] CMD_IDLE = 2'b11;

`ifdef JTAG_SCAN_IDLE_EN
  localparam int EXTRA_TCKS = IDLE_TCKS;
`else
  localparam int EXTRA_TCKS = 0;
`endif

  localparam int PW = $clog2(MAX_LEN + 7 + IDLE_TCKS) + 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]      DIV_LOAD = DW'(CLK_DIV - 1);
  localparam logic [MAX_LEN-1:0] ONE      = MAX_LEN'(1);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // Period index of the first shift bit: after Select-DR, Capture (DR) or Select-DR, Select-IR, Capture (IR).
  function automatic logic [PW-1:0] shift_first(input logic [1:0] c);
    return (c == CMD_IR) ? PW'(4) : PW'(3);
  endfunction

  function automatic logic in_shift(input logic [1:0] c, input logic [LEN_W-1:0] n,
                                    input logic [PW-1:0] p);
    logic [PW-1:0] s0;
    s0 = shift_first(c);
    return ((c == CMD_DR) || (c == CMD_IR)) && (p >= s0) && (p < s0 + PW'(n));
  endfunction

  function automatic logic [MAX_LEN-1:0] bit_mask(input logic [1:0] c, input logic [PW-1:0] p);
    return ONE << (p - shift_first(c));
  endfunction

  function automatic logic tms_at(input logic [1:0] c, input logic [LEN_W-1:0] n,
                                  input logic [PW-1:0] p);
    logic [PW-1:0] s0;
    logic [PW-1:0] se;
    logic          t;
    s0 = shift_first(c);
    se = s0 + PW'(n);
    t  = 1'b0;
    case (c)
      CMD_RST:  t = (p < PW'(5));
      CMD_IDLE: t = 1'b0;
      default: begin
        if (p < s0)      t = (c == CMD_IR) ? (p < PW'(2)) : (p == '0);
        else if (p < se) t = (p == se - PW'(1));
        else             t = (p == se);
      end
    endcase
    return t;
  endfunction

  function automatic logic tdi_at(input logic [1:0] c, input logic [LEN_W-1:0] n,
                                  input logic [MAX_LEN-1:0] d, input logic [PW-1:0] p);
    return in_shift(c, n, p) && (|(d & bit_mask(c, p)));
  endfunction

  function automatic logic [PW-1:0] k_of(input logic [1:0] c, input logic [LEN_W-1:0] n);
    logic [PW-1:0] k;
    case (c)
      CMD_RST:  k = PW'(6);
      CMD_IDLE: k = PW'(n);
      CMD_DR:   k = PW'(n) + PW'(5 + EXTRA_TCKS);
      default:  k = PW'(n) + PW'(6 + EXTRA_TCKS);
    endcase
    return k;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         cmd_q;
  logic [LEN_W-1:0]   len_q;
  logic [MAX_LEN-1:0] din_q;
  logic [MAX_LEN-1:0] tdo_q;
  logic [PW-1:0]      k_q;
  logic [PW-1:0]      per_q;
  logic [DW-1:0]      div_q;
  logic               tck_q, tms_q, tdi_q;

  logic [LEN_W-1:0]   len_c;
  logic [PW-1:0]      per_nx;
  logic               zero_len, accept, active, tick, rise, fall;

  always_comb begin
    len_c    = (len > LEN_MAX) ? LEN_MAX : len;
    zero_len = (cmd != CMD_RST) && (len_c == '0);
    accept   = start && (state_q != S_RUN);
    active   = (state_q == S_RUN) && (per_q != k_q);
    tick     = active && (div_q == '0);
    rise     = tick && !tck_q;
    fall     = tick && tck_q;
    per_nx   = per_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = zero_len ? S_FINISH : S_RUN;
      S_RUN:    if (per_q == k_q) state_d = S_FINISH;
      S_FINISH: begin
        if (accept) state_d = zero_len ? S_FINISH : S_RUN;
        else        state_d = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // TMS/TDI only move at entry or on a TCK fall, so they are settled a full half-period before each rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= '0;
      len_q <= '0;
      din_q <= '0;
      tdo_q <= '0;
      k_q   <= '0;
      per_q <= '0;
      div_q <= '0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else if (accept) begin
      cmd_q <= cmd;
      len_q <= len_c;
      din_q <= tdi_data;
      k_q   <= k_of(cmd, len_c);
      per_q <= '0;
      div_q <= DIV_LOAD;
      tck_q <= 1'b0;
      if (!zero_len) begin
        tms_q <= tms_at(cmd, len_c, '0);
        tdi_q <= tdi_at(cmd, len_c, tdi_data, '0);
      end
      if (((cmd == CMD_DR) || (cmd == CMD_IR)) && !zero_len)
        tdo_q <= tdo_q & ~({MAX_LEN{1'b1}} << len_c);
    end else if (active) begin
      if (tick) begin
        div_q <= DIV_LOAD;
        tck_q <= ~tck_q;
        if (rise && in_shift(cmd_q, len_q, per_q))
          tdo_q <= jtag_tdo ? (tdo_q | bit_mask(cmd_q, per_q))
                            : (tdo_q & ~bit_mask(cmd_q, per_q));
        if (fall) begin
          per_q <= per_nx;
          if (per_nx == k_q) begin
            tms_q <= 1'b0;
            tdi_q <= 1'b0;
          end else begin
            tms_q <= tms_at(cmd_q, len_q, per_nx);
            tdi_q <= tdi_at(cmd_q, len_q, din_q, per_nx);
          end
        end
      end else begin
        div_q <= div_q - DW'(1);
      end
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_FINISH);
  assign jtag_tck = tck_q;
  assign jtag_tms = tms_q;
  assign jtag_tdi = tdi_q;
  assign tdo_data = tdo_q;

endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

Parametrised JTAG scan sequencer that drives the debug TAP port (TCK/TMS/TDI, sampling TDO) from a simple command/handshake interface. It generalises the fixed-function JTAG data writer used to poke the e200 debug module: scan length, TCK divide ratio and command mode are selectable per operation. It sits between a test/debug controller (bench driver, or an on-chip host bridge) and the SoC `jtag_*` pins.

## Interface
Parameters:
- `MAX_LEN`, 64: widest supported IR/DR scan, in bits.
- `LEN_W`, 7: width of `len`; must satisfy 2^LEN_W > MAX_LEN.
- `CLK_DIV`, 2: `clk` cycles per TCK half-period, ≥1.
- `IDLE_TCKS`, 4: extra Run-Test/Idle TCKs after each scan. Only used when the macro in Configuration is defined.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `start` in 1: command request, sampled when `busy`=0.
- `cmd` in 2: 00 DR scan, 01 IR scan, 10 TAP reset, 11 idle-run.
- `len` in LEN_W: scan bit count, or TCK count for idle-run.
- `tdi_data` in MAX_LEN: shift-in data, LSB first.
- `tdo_data` out MAX_LEN: captured TDO, right-aligned.
- `busy` out 1: command in progress.
- `done` out 1: one-cycle completion pulse.
- `jtag_tck` out 1, `jtag_tms` out 1, `jtag_tdi` out 1: TAP drive.
- `jtag_tdo` in 1: TAP return.

## Operation
- Reset values: `jtag_tck`=0, `jtag_tms`=1, `jtag_tdi`=0, `busy`=0, `done`=0, `tdo_data`=0. The TAP state is unknown after reset; the first command should be TAP reset.
- FSM states: IDLE, RUN, FINISH. `start` in IDLE latches `cmd`, `len` (clamped to MAX_LEN) and `tdi_data`, then enters RUN. `start` while `busy` is ignored.
- RUN drives a per-command TMS schedule of K TCK periods. Before each command the sequencer assumes the TAP is in Run-Test/Idle (RTI), except for TAP reset.
  - TAP reset: TMS 1,1,1,1,1,0; K=6; ends in RTI.
  - DR scan: TMS 1,0,0, then `len` shift bits with TMS=0 except the last (TMS=1), then 1,0. K=len+5.
  - IR scan: TMS 1,1,0,0, then `len` shift bits as above, then 1,0. K=len+6.
  - Idle-run: TMS=0 for `len` TCKs; `jtag_tdi`=0; `tdo_data` unchanged.
- Shift bits:
  - `jtag_tdi` = `tdi_data[i]` during shift bit i.
  - TDO sampled on the rising TCK of shift bit i lands in `tdo_data[i]`.
  - `tdo_data[MAX_LEN-1:len]` is cleared at command start.
  - Outside shift bits, `jtag_tdi`=0.
- `len`=0 on a scan or idle-run command: no TCK activity; `done` is pulsed one cycle after acceptance; `tdo_data` is unchanged.
- FINISH: pulse `done`, clear `busy`, return to IDLE.

## Timing
- TCK is generated by a divide counter. Each half-period is CLK_DIV `clk` cycles, and TCK idles low.
- TMS and TDI change only in the cycle where TCK falls, or when RUN is entered. They are stable for CLK_DIV cycles before each rising edge.
- Sequence for an accepted `start` at cycle 0:
  - `busy`=1 from cycle 1.
  - The first TCK rise is at cycle 1+CLK_DIV.
  - The K-th falling edge is at cycle 1+2·K·CLK_DIV.
  - `done`=1 and `busy`=0 in the following cycle.
- `tdo_data` is final when `done` is asserted and holds until the next accepted command.
- After the final TCK falls, `jtag_tms`=0 (RTI hold).
- Asserting `reset` mid-command aborts immediately: all outputs return to reset values and no `done` pulse is generated.

## Configuration
- `JTAG_SCAN_IDLE_EN` defined: after each DR/IR scan, IDLE_TCKS extra TCKs with TMS=0 are appended before `done`, giving K=len+5+IDLE_TCKS for DR. TAP reset and idle-run are unaffected.
- Not defined: no extra TCKs; IDLE_TCKS is ignored.

## Test plan
- Reset, then cmd=10 with CLK_DIV=2 → exactly 6 TCK rises with TMS 1,1,1,1,1,0 sampled at each rise; `done` at cycle 26; `busy` high for cycles 1–25.
- DR scan, len=41, `tdi_data`=0x1_2345_6789_A, `jtag_tdo` looped to `jtag_tdi` → 46 TCKs; `tdo_data`=0x1_2345_6789_A with bits 63:41 zero.
- IR scan, len=5, `tdi_data`=0x11, `jtag_tdo` tied 1 → TMS sequence 1,1,0,0,0,0,0,0,1,1,0 (11 TCKs); `tdo_data`=0x1F.
- `start` pulsed mid-scan, and `len`=0 scan → mid-scan `start` ignored with the sequence unaltered; `len`=0 gives no TCK edges and `done` one cycle after acceptance.
- `reset` asserted at the 20th TCK of a 41-bit DR scan → same-cycle (async) return to `jtag_tms`=1, `jtag_tck`=0, `busy`=0, no `done`; a following TAP reset completes normally.
- With `JTAG_SCAN_IDLE_EN` defined and IDLE_TCKS=4, DR scan len=8 → 17 TCKs, the last 4 with TMS=0.
